// File: rtl/rvc_fetch_aligner_if.sv
// Bus bundle for rvc_fetch_aligner: fetch request/response, instruction issue
// handshake and redirect. The aligner connects through the slave modport.
// The master modport is for whatever drives the fetch side and consumes the
// issued instructions.
interface rvc_fetch_aligner_if;
  logic [31:0] oFETCH_PC;
  logic        iFETCH_VALID;
  logic [31:0] iFETCH_DATA;
  logic        oFETCH_READY;
  logic        oINST_VALID;
  logic [31:0] oINST;
  logic [31:0] oINST_PC;
  logic        oINST_IS_C;
  logic        oINST_ILLEGAL;
  logic        iINST_READY;
  logic        iFLUSH;
  logic [31:0] iFLUSH_PC;

  modport master (
    input  oFETCH_PC, oFETCH_READY, oINST_VALID, oINST, oINST_PC,
           oINST_IS_C, oINST_ILLEGAL,
    output iFETCH_VALID, iFETCH_DATA, iINST_READY, iFLUSH, iFLUSH_PC
  );

  modport slave (
    output oFETCH_PC, oFETCH_READY, oINST_VALID, oINST, oINST_PC,
           oINST_IS_C, oINST_ILLEGAL,
    input  iFETCH_VALID, iFETCH_DATA, iINST_READY, iFLUSH, iFLUSH_PC
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: turns a stream of aligned 32-bit fetch words into a stream
// of complete RV32/RVC instructions, each tagged with its PC. It also stitches
// together 32-bit instructions that straddle two fetch words.
// Optional feature: define RVC_ALIGN_ZERO_ILLEGAL_EN to flag issued all-zero
// compressed parcels on oINST_ILLEGAL. Without it, oINST_ILLEGAL is tied to 0.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               iCLK,
  input logic               iRST_N,
  rvc_fetch_aligner_if.slave bus
);

  // Sequencer states: which part of the buffered word is issued next.
  localparam logic [2:0] ST_EMPTY   = 3'd0;
  localparam logic [2:0] ST_LO      = 3'd1;
  localparam logic [2:0] ST_HI      = 3'd2;
  localparam logic [2:0] ST_HI_WAIT = 3'd3;
  localparam logic [2:0] ST_SPAN    = 3'd4;

  logic [2:0]  state_q,    state_d;
  logic [31:0] word_q,     word_d;
  logic [31:0] wordAddr_q, wordAddr_d;
  logic [15:0] res_q,      res_d;
  logic [31:0] resAddr_q,  resAddr_d;
  logic        skip_q,     skip_d;
  logic [31:0] fetchPc_q,  fetchPc_d;

  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instIsC;
  logic        fetchReady;
  logic        accept;
  logic        consume;

  // Halfword-address bits that are architecturally ignored.
  logic unusedBits;
  assign unusedBits = bus.iFLUSH_PC[0];

  // Moore decode of the issue port and fetch-ready from the buffered state.
  always_comb begin
    instValid  = 1'b0;
    instData   = 32'h0;
    instPc     = 32'h0;
    instIsC    = 1'b0;
    fetchReady = 1'b0;
    case (state_q)
      ST_EMPTY, ST_HI_WAIT: begin
        fetchReady = 1'b1;
      end
      ST_LO: begin
        instValid = 1'b1;
        instPc    = wordAddr_q;
        if (word_q[1:0] != 2'b11) begin
          instData = {16'h0, word_q[15:0]};
          instIsC  = 1'b1;
        end else begin
          instData = word_q;
        end
      end
      ST_HI: begin
        if (word_q[17:16] != 2'b11) begin
          instValid = 1'b1;
          instData  = {16'h0, word_q[31:16]};
          instPc    = wordAddr_q + 32'd2;
          instIsC   = 1'b1;
        end
      end
      ST_SPAN: begin
        instValid = 1'b1;
        instData  = {word_q[15:0], res_q};
        instPc    = resAddr_q;
      end
      default: begin
        fetchReady = 1'b0;
      end
    endcase
  end

  assign accept  = fetchReady & bus.iFETCH_VALID;
  assign consume = instValid & bus.iINST_READY;

  assign bus.oFETCH_PC    = fetchPc_q;
  assign bus.oFETCH_READY = fetchReady;
  assign bus.oINST_VALID  = instValid;
  assign bus.oINST        = instData;
  assign bus.oINST_PC     = instPc;
  assign bus.oINST_IS_C   = instIsC;

`ifdef RVC_ALIGN_ZERO_ILLEGAL_EN
  // The all-zero compressed parcel is a reserved encoding; flag it alongside the issue.
  assign bus.oINST_ILLEGAL = instValid & instIsC & (instData[15:0] == 16'h0000);
`else
  assign bus.oINST_ILLEGAL = 1'b0;
`endif

  // Next-state logic: a redirect overrides everything, otherwise walk the parcels.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    wordAddr_d = wordAddr_q;
    res_d      = res_q;
    resAddr_d  = resAddr_q;
    skip_d     = skip_q;
    fetchPc_d  = fetchPc_q;
    if (bus.iFLUSH) begin
      state_d   = ST_EMPTY;
      skip_d    = bus.iFLUSH_PC[1];
      fetchPc_d = {bus.iFLUSH_PC[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            word_d     = bus.iFETCH_DATA;
            wordAddr_d = fetchPc_q;
            fetchPc_d  = fetchPc_q + 32'd4;
            if (skip_q) begin
              state_d = ST_HI;
              skip_d  = 1'b0;
            end else begin
              state_d = ST_LO;
            end
          end
        end
        ST_LO: begin
          if (consume) begin
            state_d = (word_q[1:0] == 2'b11) ? ST_EMPTY : ST_HI;
          end
        end
        ST_HI: begin
          if (word_q[17:16] != 2'b11) begin
            if (consume) begin
              state_d = ST_EMPTY;
            end
          end else begin
            res_d     = word_q[31:16];
            resAddr_d = wordAddr_q + 32'd2;
            state_d   = ST_HI_WAIT;
          end
        end
        ST_HI_WAIT: begin
          if (accept) begin
            word_d     = bus.iFETCH_DATA;
            wordAddr_d = fetchPc_q;
            fetchPc_d  = fetchPc_q + 32'd4;
            state_d    = ST_SPAN;
          end
        end
        ST_SPAN: begin
          if (consume) begin
            state_d = ST_HI;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and buffer registers; reset drops any buffered instructions.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_EMPTY;
      word_q     <= 32'h0;
      wordAddr_q <= 32'h0;
      res_q      <= 16'h0;
      resAddr_q  <= 32'h0;
      skip_q     <= RESET_PC[1];
      fetchPc_q  <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      wordAddr_q <= wordAddr_d;
      res_q      <= res_d;
      resAddr_q  <= resAddr_d;
      skip_q     <= skip_d;
      fetchPc_q  <= fetchPc_d;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed testbench for rvc_fetch_aligner. Each vector holds the outputs
// expected during one cycle and the inputs applied for the following edge.
// Expected values are computed by hand.
module tb_rvc_fetch_aligner;

  logic iCLK;
  logic iRST_N;
  rvc_fetch_aligner_if bus();

  rvc_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        ir;
    logic        fl;
    logic [31:0] fpc;
    logic        eValid;
    logic [31:0] eInst;
    logic [31:0] ePc;
    logic        eIsC;
    logic        eFReady;
    logic [31:0] eFPc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t table_v[27];

  // Free-running clock.
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic vec_t mk(input logic fv, input logic [31:0] fd, input logic ir,
                              input logic fl, input logic [31:0] fpc,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                              input logic ec, input logic efr, input logic [31:0] efpc);
    vec_t v;
    v.fv = fv; v.fd = fd; v.ir = ir; v.fl = fl; v.fpc = fpc;
    v.eValid = ev; v.eInst = ei; v.ePc = ep; v.eIsC = ec; v.eFReady = efr; v.eFPc = efpc;
    return v;
  endfunction

  task automatic checkOne(input string name, input int idx,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic expIll;
`ifdef RVC_ALIGN_ZERO_ILLEGAL_EN
    expIll = v.eValid & v.eIsC & (v.eInst[15:0] == 16'h0000);
`else
    expIll = 1'b0;
`endif
    checkOne("valid",   idx, {31'h0, bus.oINST_VALID},   {31'h0, v.eValid});
    checkOne("inst",    idx, bus.oINST,                  v.eInst);
    checkOne("pc",      idx, bus.oINST_PC,               v.ePc);
    checkOne("isC",     idx, {31'h0, bus.oINST_IS_C},    {31'h0, v.eIsC});
    checkOne("fready",  idx, {31'h0, bus.oFETCH_READY},  {31'h0, v.eFReady});
    checkOne("fpc",     idx, bus.oFETCH_PC,              v.eFPc);
    checkOne("illegal", idx, {31'h0, bus.oINST_ILLEGAL}, {31'h0, expIll});
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iFETCH_VALID = v.fv;
    bus.iFETCH_DATA  = v.fd;
    bus.iINST_READY  = v.ir;
    bus.iFLUSH       = v.fl;
    bus.iFLUSH_PC    = v.fpc;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    checkOutput(v, idx);
    applyStimulus(v);
    @(negedge iCLK);
  endtask

  // Main sequence: reset, table vectors, then hand-written corner cases.
  initial begin
    vec_t idle;
    vec_t rstV;
    idle = mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h0);

    //            fv fd             ir fl fpc            eV eInst          ePc            eC eFR eFPc
    table_v[0]  = mk(1, 32'h0000_0513, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h0);
    table_v[1]  = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0513, 32'h0,         0, 0, 32'h4);
    table_v[2]  = mk(1, 32'h4501_0505, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h4);
    table_v[3]  = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0505, 32'h4,         1, 0, 32'h8);
    table_v[4]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_4501, 32'h6,         1, 0, 32'h8);
    table_v[5]  = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_4501, 32'h6,         1, 0, 32'h8);
    table_v[6]  = mk(1, 32'h0513_0505, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h8);
    table_v[7]  = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0505, 32'h8,         1, 0, 32'hC);
    table_v[8]  = mk(1, 32'hDEAD_BEEF, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 0, 32'hC);
    table_v[9]  = mk(1, 32'h0001_0000, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'hC);
    table_v[10] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0513, 32'hA,         0, 0, 32'h10);
    table_v[11] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0001, 32'hE,         1, 0, 32'h10);
    table_v[12] = mk(1, 32'h4501_0505, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h10);
    table_v[13] = mk(1, 32'h1234_5678, 1, 1, 32'h100A,     1, 32'h0000_0505, 32'h10,        1, 0, 32'h14);
    table_v[14] = mk(1, 32'h4501_0505, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h1008);
    table_v[15] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_4501, 32'h100A,      1, 0, 32'h100C);
    table_v[16] = mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,         0, 1, 32'h100C);
    table_v[17] = mk(1, 32'h0001_0000, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'hFFFF_FFFC);
    table_v[18] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 32'h0);
    table_v[19] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0001, 32'hFFFF_FFFE, 1, 0, 32'h0);
    table_v[20] = mk(0, 32'h0,         1, 1, 32'h0000_0203, 0, 32'h0,        32'h0,         0, 1, 32'h0);
    table_v[21] = mk(1, 32'h0513_0505, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h200);
    table_v[22] = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 0, 32'h204);
    table_v[23] = mk(1, 32'h0000_4501, 1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h204);
    table_v[24] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h4501_0513, 32'h202,       0, 0, 32'h208);
    table_v[25] = mk(0, 32'h0,         1, 0, 32'h0,        1, 32'h0000_0000, 32'h206,       1, 0, 32'h208);
    table_v[26] = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 32'h208);

    iRST_N = 1'b0;
    applyStimulus(idle);
    @(negedge iCLK);
    @(negedge iCLK);
    checkOutput(idle, 900);
    iRST_N = 1'b1;

    for (int i = 0; i < 27; i++) begin
      runVec(table_v[i], i);
    end

    // Flush while empty drops the offered word; then build a straddle and stall in SPAN.
    runVec(mk(1, 32'hFFFF_FFFF, 1, 1, 32'h300, 0, 32'h0, 32'h0, 0, 1, 32'h208), 100);
    runVec(mk(1, 32'h0513_0505, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0, 1, 32'h300), 101);
    runVec(mk(0, 32'h0,         1, 0, 32'h0,   1, 32'h0000_0505, 32'h300, 1, 0, 32'h304), 102);
    runVec(mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h0, 32'h0, 0, 0, 32'h304), 103);
    runVec(mk(1, 32'h0001_0000, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0, 1, 32'h304), 104);
    for (int k = 0; k < 5; k++) begin
      runVec(mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 32'h0000_0513, 32'h302, 0, 0, 32'h308), 105 + k);
    end
    runVec(mk(0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0513, 32'h302, 0, 0, 32'h308), 110);
    runVec(mk(0, 32'h0, 0, 0, 32'h0, 1, 32'h0000_0001, 32'h306, 1, 0, 32'h308), 111);
    runVec(mk(0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0001, 32'h306, 1, 0, 32'h308), 112);

    // Reach SPAN again and pulse reset in the middle of the cycle.
    runVec(mk(1, 32'h0513_0505, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h308), 113);
    runVec(mk(0, 32'h0,         1, 0, 32'h0, 1, 32'h0000_0505, 32'h308, 1, 0, 32'h30C), 114);
    runVec(mk(0, 32'h0,         1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h30C), 115);
    runVec(mk(1, 32'h0000_0000, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h30C), 116);
    runVec(mk(0, 32'h0,         0, 0, 32'h0, 1, 32'h0000_0513, 32'h30A, 0, 0, 32'h310), 117);
    #2;
    iRST_N = 1'b0;
    #1;
    rstV = idle;
    checkOutput(rstV, 118);
    @(negedge iCLK);
    applyStimulus(idle);
    iRST_N = 1'b1;
    runVec(mk(1, 32'h0000_0513, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h0), 119);
    runVec(mk(0, 32'h0,         1, 0, 32'h0, 1, 32'h0000_0513, 32'h0, 0, 0, 32'h4), 120);
    runVec(mk(0, 32'h0,         1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h4), 121);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
